// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, total derivations and RRRGGGBB colour expansion.
package vga_timing_pkg;
   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;
   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;
   localparam int SYNC_POL_D = 0;

   function automatic int total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int H_TOTAL_D = total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
   localparam int V_TOTAL_D = total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);

   // Replicate the top bits so full-scale 3/2-bit values reach 4'hF.
   function automatic logic [11:0] expand(input logic [7:0] c);
      return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
   endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: h/v counters and stage-0 region decode (active, sync regions, refresh, frame tick).
module vga_timing
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D
) (
   input  logic       pixel_clk,
   input  logic       rst,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       active,
   output logic       hs_region,
   output logic       vs_region,
   output logic       refresh,
   output logic       frame_tick
);
   localparam logic [9:0] H_LAST = 10'(total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
   localparam logic [9:0] V_LAST = 10'(total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] H_S0   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_S1   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_S0   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_S1   = 10'(V_ACTIVE + V_FP + V_SYNC);

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 10'd1;
         if (h_cnt == H_LAST) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end
   end

   always_comb begin
      active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs_region  = (h_cnt >= H_S0) && (h_cnt < H_S1);
      vs_region  = (v_cnt >= V_S0) && (v_cnt < V_S1);
      refresh    = rst || !active;
      frame_tick = !rst && (h_cnt == '0) && (v_cnt == V_ACT);
   end
endmodule

// File: rtl/vga_pixel_out.sv
// vga_pixel_out: VGA timing plus a two-stage pipeline aligning colour and sync at the DAC pins.
module vga_pixel_out
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   parameter int SYNC_POL = SYNC_POL_D
) (
   input  logic       pixel_clk,
   input  logic       rst,
   input  logic [7:0] tru_8_bit,
   output logic       refresh,
   output logic       frame_tick,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic       vga_hs,
   output logic       vga_vs
);
   localparam logic POL = (SYNC_POL != 0);

   logic active, hs_region, vs_region;
   logic active_d1, hs_d1, vs_d1;

   vga_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .pixel_clk (pixel_clk),
      .rst       (rst),
      .h_cnt     (pix_x),
      .v_cnt     (pix_y),
      .active    (active),
      .hs_region (hs_region),
      .vs_region (vs_region),
      .refresh   (refresh),
      .frame_tick(frame_tick)
   );

   // Stage 1 lines up with the source's own colour register; stage 2 drives the pins.
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         {active_d1, hs_d1, vs_d1} <= '0;
         {vga_r, vga_g, vga_b}     <= '0;
         vga_hs                    <= ~POL;
         vga_vs                    <= ~POL;
      end else begin
         active_d1             <= active;
         hs_d1                 <= hs_region;
         vs_d1                 <= vs_region;
         {vga_r, vga_g, vga_b} <= active_d1 ? expand(tru_8_bit) : 12'h000;
         vga_hs                <= hs_d1 ~^ POL;
         vga_vs                <= vs_d1 ~^ POL;
      end
   end
endmodule

// File: tb/tb_vga_pixel_out.sv
// tb_vga_pixel_out: closed-loop colour source, scoreboard of pin values, and frame/sync/reset timing checks.
module tb_vga_pixel_out;
   localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
   localparam int VA = 8, VFP = 2, VS = 2, VBP = 3;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;

   typedef struct packed {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } exp_t;
   localparam exp_t BLANK = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};

   logic       pixel_clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tru_8_bit = 8'h00;
   logic       refresh, frame_tick, vga_hs, vga_vs;
   logic [9:0] pix_x, pix_y;
   logic [3:0] vga_r, vga_g, vga_b;

   exp_t       q[$];
   int         tests = 0, fails = 0, cyc = 0, h = 0, v = 0;
   logic [7:0] nxt = 8'h00;
   bit         ff_mode = 1'b0;

   vga_pixel_out #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0)
   ) dut (
      .pixel_clk (pixel_clk),
      .rst       (rst),
      .tru_8_bit (tru_8_bit),
      .refresh   (refresh),
      .frame_tick(frame_tick),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .vga_r     (vga_r),
      .vga_g     (vga_g),
      .vga_b     (vga_b),
      .vga_hs    (vga_hs),
      .vga_vs    (vga_vs)
   );

   always #5 pixel_clk = ~pixel_clk;

   function automatic logic [11:0] exp_rgb(input logic [7:0] c);
      logic [2:0] r, g;
      logic [1:0] b;
      r = c[7:5];
      g = c[4:2];
      b = c[1:0];
      return {r, r[2], g, g[2], b, b};
   endfunction

   function automatic logic [7:0] src(input int x, input int y);
      return (x == 0 && y == 0) ? 8'b101_011_10 : 8'(x * 37 + y * 11 + 3);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // One pixel clock: advance the position model, drive the registered source, score outputs.
   task automatic tick(input logic nr);
      logic r0;
      bit   act;
      exp_t e;
      r0 = rst;
      @(posedge pixel_clk);
      #1;
      cyc++;
      if (r0) begin
         h = 0;
         v = 0;
      end else if (h == HT - 1) begin
         h = 0;
         v = (v == VT - 1) ? 0 : v + 1;
      end else h++;
      rst = nr;
      tru_8_bit = nxt;
      #1;
      act = (h < HA) && (v < VA);
      chk("pix_x", 32'(pix_x), h);
      chk("pix_y", 32'(pix_y), v);
      chk("refresh", 32'(refresh), 32'(rst || !act));
      chk("frame_tick", 32'(frame_tick), 32'(!rst && h == 0 && v == VA));
      nxt = ff_mode ? 8'hFF : (refresh ? 8'h00 : src(h, v));
      if (r0) begin
         q.delete();
         q.push_back(BLANK);
         q.push_back(BLANK);
      end
      e.rgb = act ? exp_rgb(nxt) : 12'h000;
      e.hs  = !(h >= HA + HFP && h < HA + HFP + HS);
      e.vs  = !(v >= VA + VFP && v < VA + VFP + VS);
      q.push_back(e);
      if (q.size() > 2) begin
         e = q.pop_front();
         chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
         chk("vga_hs", 32'(vga_hs), 32'(e.hs));
         chk("vga_vs", 32'(vga_vs), 32'(e.vs));
      end
   endtask

   initial begin
      int t0, t1, vs_low, run, n;
      logic hs_prev;
      tick(1'b1);
      chk("refresh_in_rst", 32'(refresh), 32'd1);
      chk("tick_in_rst", 32'(frame_tick), 32'd0);
      chk("hs_rst", 32'(vga_hs), 32'd1);
      chk("vs_rst", 32'(vga_vs), 32'd1);
      chk("rgb_rst", 32'({vga_r, vga_g, vga_b}), 32'd0);
      tick(1'b0);
      chk("start_x", 32'(pix_x), 32'd0);
      chk("start_y", 32'(pix_y), 32'd0);
      tick(1'b0);
      tick(1'b0);
      chk("r_at_00", 32'(vga_r), 32'hB);
      chk("g_at_00", 32'(vga_g), 32'h6);
      chk("b_at_00", 32'(vga_b), 32'hA);

      t0 = -1;
      for (int i = 0; i < HT * VT && t0 < 0; i++) begin
         tick(1'b0);
         if (frame_tick) t0 = cyc;
      end
      chk("first_tick_seen", 32'(t0 >= 0), 32'd1);
      t1 = -1;
      vs_low = 0;
      run = 0;
      hs_prev = vga_hs;
      for (int i = 0; i < HT * VT; i++) begin
         tick(1'b0);
         if (!vga_vs) vs_low++;
         if (!vga_hs) run++;
         if (!vga_hs && hs_prev) chk("hs_fall_pos", h, HA + HFP + 2);
         if (vga_hs && !hs_prev) begin
            chk("hs_low_len", run, HS);
            run = 0;
         end
         hs_prev = vga_hs;
         if (frame_tick && t1 < 0) t1 = cyc;
      end
      chk("frame_period", t1 - t0, HT * VT);
      chk("vs_low_cycles", vs_low, VS * HT);

      ff_mode = 1'b1;
      for (int i = 0; i < HT * VT + 3; i++) tick(1'b0);
      ff_mode = 1'b0;
      for (int i = 0; i < HT * 2; i++) tick(1'b0);

      for (int i = 0; i < HT * VT && !(h == 10 && v == 5); i++) tick(1'b0);
      chk("pre_rst_pos", 32'(h == 10 && v == 5), 32'd1);
      tick(1'b1);
      chk("refresh_mid_rst", 32'(refresh), 32'd1);
      tick(1'b0);
      chk("restart_x", 32'(pix_x), 32'd0);
      chk("restart_y", 32'(pix_y), 32'd0);
      n = 0;
      while (!frame_tick && n < HT * VT + 5) begin
         tick(1'b0);
         n++;
      end
      chk("tick_after_rst", n, VA * HT);
      for (int i = 0; i < 4; i++) tick(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
